// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, ALU ops,
// datapath selector codes, FSM states and the opcode-decode payload.
package mc_ctrl_pkg;

  localparam int unsigned OP_R    = 0;
  localparam int unsigned OP_J    = 2;
  localparam int unsigned OP_JAL  = 3;
  localparam int unsigned OP_BEQ  = 4;
  localparam int unsigned OP_BNE  = 5;
  localparam int unsigned OP_ADDI = 8;
  localparam int unsigned OP_SLTI = 10;
  localparam int unsigned OP_ANDI = 12;
  localparam int unsigned OP_ORI  = 13;
  localparam int unsigned OP_XORI = 14;
  localparam int unsigned OP_LUI  = 15;
  localparam int unsigned OP_LW   = 35;
  localparam int unsigned OP_SW   = 43;

  localparam int unsigned ALU_CODE_W = 3;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;
  localparam logic [2:0] ALU_LUI   = 3'b111;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_RA  = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_OUT  = 2'b01;
  localparam logic [1:0] PCS_JUMP = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB,
    S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL, CLS_R, CLS_MEM, CLS_IMM, CLS_BRANCH, CLS_JUMP
  } op_class_t;

  typedef struct packed {
    op_class_t  cls;
    logic [2:0] alu_i;    // ALU op for immediate-class instructions
    logic       legal;
    logic       is_load;  // lw vs sw
    logic       is_bne;   // bne vs beq
    logic       is_link;  // jal vs j
  } dec_t;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> instruction register / datapath bundle.
// master: the controller (consumes Opcode/mem_ready, drives control).
// slave : the datapath side.
interface multi_cycle_control_if #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned CNT_W    = 32
);
  logic [OPCODE_W-1:0] Opcode;
  logic                mem_ready;
  logic                PC_Write;
  logic                PC_Write_Cond;
  logic                PC_Write_Not_Equal;
  logic                IorD;
  logic                Mem_Read;
  logic                Mem_Write;
  logic                IR_Write;
  logic [1:0]          Reg_Dst;
  logic [1:0]          Mem_to_Reg;
  logic                Reg_Write;
  logic                ALU_Src_A;
  logic [1:0]          ALU_Src_B;
  logic [ALUOP_W-1:0]  ALU_Op;
  logic [1:0]          PC_Source;
  logic                illegal_op;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  Opcode, mem_ready,
    output PC_Write, PC_Write_Cond, PC_Write_Not_Equal, IorD, Mem_Read,
           Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write, ALU_Src_A,
           ALU_Src_B, ALU_Op, PC_Source, illegal_op, instr_count
  );

  modport slave (
    output Opcode, mem_ready,
    input  PC_Write, PC_Write_Cond, PC_Write_Not_Equal, IorD, Mem_Read,
           Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write, ALU_Src_A,
           ALU_Src_B, ALU_Op, PC_Source, illegal_op, instr_count
  );
endinterface

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier shared by next-state and output logic.
// Ports: op (opcode), dec (class, immediate ALU op, legal and sub-kind flags).
module mc_opcode_decode
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] op,
  output dec_t                dec
);

  always_comb begin
    dec       = '0;
    dec.cls   = CLS_ILLEGAL;
    dec.alu_i = ALU_ADD;
    case (op)
      OPCODE_W'(OP_R):    begin dec.cls = CLS_R;      dec.legal = 1'b1; end
      OPCODE_W'(OP_LW):   begin dec.cls = CLS_MEM;    dec.legal = 1'b1; dec.is_load = 1'b1; end
      OPCODE_W'(OP_SW):   begin dec.cls = CLS_MEM;    dec.legal = 1'b1; end
      OPCODE_W'(OP_ADDI): begin dec.cls = CLS_IMM;    dec.legal = 1'b1; dec.alu_i = ALU_ADD; end
      OPCODE_W'(OP_ANDI): begin dec.cls = CLS_IMM;    dec.legal = 1'b1; dec.alu_i = ALU_AND; end
      OPCODE_W'(OP_ORI):  begin dec.cls = CLS_IMM;    dec.legal = 1'b1; dec.alu_i = ALU_OR;  end
      OPCODE_W'(OP_SLTI): begin dec.cls = CLS_IMM;    dec.legal = 1'b1; dec.alu_i = ALU_SLT; end
      OPCODE_W'(OP_XORI): begin dec.cls = CLS_IMM;    dec.legal = 1'b1; dec.alu_i = ALU_XOR; end
      OPCODE_W'(OP_LUI):  begin dec.cls = CLS_IMM;    dec.legal = 1'b1; dec.alu_i = ALU_LUI; end
      OPCODE_W'(OP_BEQ):  begin dec.cls = CLS_BRANCH; dec.legal = 1'b1; end
      OPCODE_W'(OP_BNE):  begin dec.cls = CLS_BRANCH; dec.legal = 1'b1; dec.is_bne = 1'b1; end
      OPCODE_W'(OP_J):    begin dec.cls = CLS_JUMP;   dec.legal = 1'b1; end
      OPCODE_W'(OP_JAL):  begin dec.cls = CLS_JUMP;   dec.legal = 1'b1; dec.is_link = 1'b1; end
      default:            dec.cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle instruction sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath control per state.
// Ports: clk, reset (async active-low), bus (master side: Opcode/mem_ready in,
// datapath controls, illegal_op pulse and retired-instruction count out).
module multi_cycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  multi_cycle_control_if.master bus
);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [OPCODE_W-1:0] op_sel;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          alu_c;
  logic                retire_c;
  dec_t                dec;

  // In DECODE the live opcode steers the branch; afterwards the captured copy does.
  assign op_sel = (state_q == S_DECODE) ? bus.Opcode : op_q;

  mc_opcode_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .op  (op_sel),
    .dec (dec)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Opcode capture and retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (state_q == S_DECODE) op_q <= bus.Opcode;
      if (retire_c)            cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.instr_count = cnt_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (dec.cls)
          CLS_R:      state_d = S_EXEC_R;
          CLS_MEM:    state_d = S_MEM_ADDR;
          CLS_IMM:    state_d = S_EXEC_I;
          CLS_BRANCH: state_d = S_BRANCH;
          CLS_JUMP:   state_d = S_JUMP;
          default:    state_d = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_MEM_ADDR:  state_d = dec.is_load ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: Moore per state, except IR/PC write in FETCH following mem_ready
  always_comb begin
    bus.PC_Write           = 1'b0;
    bus.PC_Write_Cond      = 1'b0;
    bus.PC_Write_Not_Equal = 1'b0;
    bus.IorD               = 1'b0;
    bus.Mem_Read           = 1'b0;
    bus.Mem_Write          = 1'b0;
    bus.IR_Write           = 1'b0;
    bus.Reg_Dst            = DST_RT;
    bus.Mem_to_Reg         = M2R_ALU;
    bus.Reg_Write          = 1'b0;
    bus.ALU_Src_A          = 1'b0;
    bus.ALU_Src_B          = SRCB_RT;
    bus.PC_Source          = PCS_ALU;
    bus.illegal_op         = 1'b0;
    alu_c                  = ALU_ADD;
    retire_c               = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.Mem_Read  = 1'b1;
        bus.ALU_Src_B = SRCB_FOUR;
        bus.IR_Write  = bus.mem_ready;
        bus.PC_Write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALU_Src_B  = SRCB_IMM2;
        bus.illegal_op = ~dec.legal;
      end
      S_EXEC_R: begin
        bus.ALU_Src_A = 1'b1;
        alu_c         = ALU_FUNCT;
      end
      S_EXEC_I: begin
        bus.ALU_Src_A = 1'b1;
        bus.ALU_Src_B = SRCB_IMM;
        alu_c         = dec.alu_i;
      end
      S_ALU_WB: begin
        bus.Reg_Write = 1'b1;
        bus.Reg_Dst   = (dec.cls == CLS_R) ? DST_RD : DST_RT;
        retire_c      = 1'b1;
      end
      S_MEM_ADDR: begin
        bus.ALU_Src_A = 1'b1;
        bus.ALU_Src_B = SRCB_IMM;
      end
      S_MEM_READ: begin
        bus.Mem_Read = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_MEM_WB: begin
        bus.Reg_Write  = 1'b1;
        bus.Mem_to_Reg = M2R_MDR;
        retire_c       = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.Mem_Write = 1'b1;
        bus.IorD      = 1'b1;
        retire_c      = bus.mem_ready;
      end
      S_BRANCH: begin
        bus.ALU_Src_A          = 1'b1;
        alu_c                  = ALU_SUB;
        bus.PC_Source          = PCS_OUT;
        bus.PC_Write_Cond      = ~dec.is_bne;
        bus.PC_Write_Not_Equal = dec.is_bne;
        retire_c               = 1'b1;
      end
      S_JUMP: begin
        bus.PC_Write  = 1'b1;
        bus.PC_Source = PCS_JUMP;
        if (dec.is_link) begin
          bus.Reg_Write  = 1'b1;
          bus.Reg_Dst    = DST_RA;
          bus.Mem_to_Reg = M2R_PC;
        end
        retire_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Wider ALU_Op buses carry the 3-bit code with zero upper bits.
  assign bus.ALU_Op = ALUOP_W'(alu_c);

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control with a 4-bit counter to reach wrap.
module tb_multi_cycle_control;
  import mc_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  multi_cycle_control_if #(.OPCODE_W(6), .ALUOP_W(3), .CNT_W(4)) bus ();

  multi_cycle_control #(.OPCODE_W(6), .ALUOP_W(3), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input state_t exp);
    chk(tag, 32'(dut.state_q), 32'(exp));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    bus.Opcode    = 6'd0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: everything zero
    st("rst_state", S_IDLE);
    chk("rst_memrd", 32'(bus.Mem_Read), 32'd0);
    chk("rst_pcw", 32'(bus.PC_Write), 32'd0);
    chk("rst_irw", 32'(bus.IR_Write), 32'd0);
    chk("rst_aluop", 32'(bus.ALU_Op), 32'd0);
    chk("rst_srcb", 32'(bus.ALU_Src_B), 32'd0);
    chk("rst_cnt", 32'(bus.instr_count), 32'd0);

    // R-type: IDLE -> FETCH -> DECODE -> EXEC_R -> ALU_WB
    reset = 1'b1;
    nxt();
    st("r_fetch", S_FETCH);
    chk("r_fetch_memrd", 32'(bus.Mem_Read), 32'd1);
    chk("r_fetch_irw", 32'(bus.IR_Write), 32'd1);
    chk("r_fetch_pcw", 32'(bus.PC_Write), 32'd1);
    chk("r_fetch_srcb", 32'(bus.ALU_Src_B), 32'd1);
    nxt();
    st("r_decode", S_DECODE);
    chk("r_dec_srcb", 32'(bus.ALU_Src_B), 32'd3);
    chk("r_dec_ill", 32'(bus.illegal_op), 32'd0);
    nxt();
    st("r_exec", S_EXEC_R);
    chk("r_exec_srca", 32'(bus.ALU_Src_A), 32'd1);
    chk("r_exec_aluop", 32'(bus.ALU_Op), 32'd2);
    nxt();
    st("r_wb", S_ALU_WB);
    chk("r_wb_regw", 32'(bus.Reg_Write), 32'd1);
    chk("r_wb_dst", 32'(bus.Reg_Dst), 32'd1);
    chk("r_wb_cnt_before", 32'(bus.instr_count), 32'd0);
    nxt();
    st("r_back_fetch", S_FETCH);
    chk("r_cnt", 32'(bus.instr_count), 32'd1);

    // FETCH stall while memory not ready
    bus.mem_ready = 1'b0;
    #1;
    chk("stall_irw", 32'(bus.IR_Write), 32'd0);
    chk("stall_pcw", 32'(bus.PC_Write), 32'd0);
    nxt();
    st("stall_fetch", S_FETCH);
    chk("stall_memrd", 32'(bus.Mem_Read), 32'd1);

    // lw with three wait cycles in MEM_READ
    bus.mem_ready = 1'b1;
    bus.Opcode    = 6'd35;
    nxt();
    st("lw_decode", S_DECODE);
    nxt();
    st("lw_addr", S_MEM_ADDR);
    chk("lw_addr_srcb", 32'(bus.ALU_Src_B), 32'd2);
    bus.mem_ready = 1'b0;
    nxt();
    st("lw_rd1", S_MEM_READ);
    chk("lw_rd1_memrd", 32'(bus.Mem_Read), 32'd1);
    chk("lw_rd1_iord", 32'(bus.IorD), 32'd1);
    chk("lw_rd1_memwr", 32'(bus.Mem_Write), 32'd0);
    bus.Opcode = 6'd63;   // must be ignored outside DECODE
    nxt();
    st("lw_rd2", S_MEM_READ);
    nxt();
    st("lw_rd3", S_MEM_READ);
    chk("lw_rd3_memrd", 32'(bus.Mem_Read), 32'd1);
    bus.mem_ready = 1'b1;
    #1;
    chk("lw_rd4_memrd", 32'(bus.Mem_Read), 32'd1);
    chk("lw_rd4_iord", 32'(bus.IorD), 32'd1);
    nxt();
    st("lw_wb", S_MEM_WB);
    chk("lw_wb_regw", 32'(bus.Reg_Write), 32'd1);
    chk("lw_wb_m2r", 32'(bus.Mem_to_Reg), 32'd1);
    chk("lw_wb_memrd", 32'(bus.Mem_Read), 32'd0);
    nxt();
    st("lw_fetch", S_FETCH);
    chk("lw_cnt", 32'(bus.instr_count), 32'd2);

    // bne
    bus.Opcode = 6'd5;
    nxt();
    nxt();
    st("bne_state", S_BRANCH);
    chk("bne_ne", 32'(bus.PC_Write_Not_Equal), 32'd1);
    chk("bne_cond", 32'(bus.PC_Write_Cond), 32'd0);
    chk("bne_aluop", 32'(bus.ALU_Op), 32'd1);
    chk("bne_pcsrc", 32'(bus.PC_Source), 32'd1);
    chk("bne_regw", 32'(bus.Reg_Write), 32'd0);
    nxt();
    chk("bne_cnt", 32'(bus.instr_count), 32'd3);

    // beq
    bus.Opcode = 6'd4;
    nxt();
    nxt();
    chk("beq_cond", 32'(bus.PC_Write_Cond), 32'd1);
    chk("beq_ne", 32'(bus.PC_Write_Not_Equal), 32'd0);
    nxt();
    chk("beq_cnt", 32'(bus.instr_count), 32'd4);

    // jal
    bus.Opcode = 6'd3;
    nxt();
    nxt();
    st("jal_state", S_JUMP);
    chk("jal_pcw", 32'(bus.PC_Write), 32'd1);
    chk("jal_pcsrc", 32'(bus.PC_Source), 32'd2);
    chk("jal_regw", 32'(bus.Reg_Write), 32'd1);
    chk("jal_dst", 32'(bus.Reg_Dst), 32'd2);
    chk("jal_m2r", 32'(bus.Mem_to_Reg), 32'd2);
    nxt();
    st("jal_fetch", S_FETCH);
    chk("jal_cnt", 32'(bus.instr_count), 32'd5);

    // ori: EXEC_I with OR, writes rt
    bus.Opcode = 6'd13;
    nxt();
    nxt();
    st("ori_exec", S_EXEC_I);
    chk("ori_aluop", 32'(bus.ALU_Op), 32'd4);
    chk("ori_srcb", 32'(bus.ALU_Src_B), 32'd2);
    nxt();
    chk("ori_dst", 32'(bus.Reg_Dst), 32'd0);
    chk("ori_regw", 32'(bus.Reg_Write), 32'd1);
    nxt();
    chk("ori_cnt", 32'(bus.instr_count), 32'd6);

    // lui
    bus.Opcode = 6'd15;
    nxt();
    nxt();
    chk("lui_aluop", 32'(bus.ALU_Op), 32'd7);
    nxt();
    nxt();
    chk("lui_cnt", 32'(bus.instr_count), 32'd7);

    // Illegal opcode
    bus.Opcode = 6'd63;
    nxt();
    st("ill_decode", S_DECODE);
    chk("ill_pulse", 32'(bus.illegal_op), 32'd1);
    nxt();
    st("ill_fetch", S_FETCH);
    chk("ill_clear", 32'(bus.illegal_op), 32'd0);
    chk("ill_cnt", 32'(bus.instr_count), 32'd7);

    // sw with ready memory
    bus.Opcode = 6'd43;
    nxt();
    nxt();
    nxt();
    st("sw_write", S_MEM_WRITE);
    chk("sw_memwr", 32'(bus.Mem_Write), 32'd1);
    chk("sw_memrd", 32'(bus.Mem_Read), 32'd0);
    chk("sw_iord", 32'(bus.IorD), 32'd1);
    nxt();
    st("sw_fetch", S_FETCH);
    chk("sw_cnt", 32'(bus.instr_count), 32'd8);

    // sw stalled, then reset mid-write
    nxt();
    nxt();
    bus.mem_ready = 1'b0;
    nxt();
    st("sw2_write", S_MEM_WRITE);
    nxt();
    chk("sw2_stall_memwr", 32'(bus.Mem_Write), 32'd1);
    chk("sw2_stall_cnt", 32'(bus.instr_count), 32'd8);
    reset = 1'b0;
    #1;
    chk("abort_memwr", 32'(bus.Mem_Write), 32'd0);
    chk("abort_cnt", 32'(bus.instr_count), 32'd0);
    st("abort_state", S_IDLE);

    // 16 jumps wrap the 4-bit counter
    bus.mem_ready = 1'b1;
    bus.Opcode    = 6'd2;
    nxt();
    reset = 1'b1;
    nxt();
    st("wrap_fetch", S_FETCH);
    for (int i = 0; i < 15; i++) begin
      nxt();
      nxt();
      nxt();
    end
    chk("wrap_cnt15", 32'(bus.instr_count), 32'd15);
    nxt();
    nxt();
    chk("j_regw", 32'(bus.Reg_Write), 32'd0);
    nxt();
    chk("wrap_cnt0", 32'(bus.instr_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Multi-cycle successor to the single-cycle opcode decoder.
- A Moore FSM sequences each instruction through FETCH/DECODE/execute/memory/writeback states and drives datapath control per state.
- Memory accesses stall on a ready handshake. Opcode width and ALU-op width are parametrised, and a retired-instruction counter is added.
- Sits between the instruction register and the shared-memory multi-cycle datapath.

Parameters:
- OPCODE_W, 6, width of opcode field (Inst_31_26 generalised)
- ALUOP_W, 3, width of ALU_Op; must be >=3
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Opcode  in  OPCODE_W  opcode field from instruction register
- mem_ready  in  1  memory completes the current access this cycle
- PC_Write  out  1  unconditional PC update
- PC_Write_Cond  out  1  PC update if ALU zero (beq)
- PC_Write_Not_Equal  out  1  PC update if ALU not zero (bne)
- IorD  out  1  memory address source: 0=PC, 1=ALUOut
- Mem_Read  out  1  memory read request
- Mem_Write  out  1  memory write request
- IR_Write  out  1  load instruction register
- Reg_Dst  out  2  00=rt, 01=rd, 10=$31
- Mem_to_Reg  out  2  00=ALUOut, 01=MDR, 10=PC
- Reg_Write  out  1  register file write enable
- ALU_Src_A  out  1  0=PC, 1=rs
- ALU_Src_B  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2
- ALU_Op  out  ALUOP_W  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt, 110 xor, 111 lui; upper bits zero
- PC_Source  out  2  00=ALU, 01=ALUOut, 10=jump target
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- instr_count  out  CNT_W  instructions retired since reset

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, op_q=0, instr_count=0.
  - Every output is 0, including ALU_Op. No X outputs in any state; all don't-cares drive 0.
- IDLE: all outputs 0; next state FETCH unconditionally once reset is released.
- FETCH:
  - Drives Mem_Read=1, IorD=0, ALU_Src_A=0, ALU_Src_B=01, ALU_Op=add, PC_Source=00.
  - IR_Write and PC_Write equal mem_ready. This is the only Mealy term.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Captures Opcode into op_q.
  - ALU_Src_A=0, ALU_Src_B=11, ALU_Op=add (branch target).
  - Next state by opcode:
    - 0 (R) -> EXEC_R
    - 35/43 -> MEM_ADDR
    - 8, 12, 13, 10, 14, 15 -> EXEC_I
    - 4/5 -> BRANCH
    - 2/3 -> JUMP
    - anything else -> FETCH, with illegal_op=1 for this cycle and no count increment.
- EXEC_R: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=010 -> ALU_WB.
- EXEC_I: ALU_Src_A=1, ALU_Src_B=10, ALU_Op per op_q (addi add, andi and, ori or, slti slt, xori xor, lui lui) -> ALU_WB.
- ALU_WB: Reg_Write=1, Mem_to_Reg=00, Reg_Dst=01 if R-type else 00 -> FETCH; retires.
- MEM_ADDR: ALU_Src_A=1, ALU_Src_B=10, ALU_Op=add -> MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: Mem_Read=1, IorD=1; wait on mem_ready -> MEM_WB.
- MEM_WB: Reg_Write=1, Mem_to_Reg=01, Reg_Dst=00 -> FETCH; retires.
- MEM_WRITE: Mem_Write=1, IorD=1; wait on mem_ready -> FETCH; retires on the mem_ready cycle.
- BRANCH: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=sub, PC_Source=01; PC_Write_Cond=1 (beq) or PC_Write_Not_Equal=1 (bne); Reg_Write=0 -> FETCH; retires.
- JUMP: PC_Write=1, PC_Source=10; jal additionally drives Reg_Write=1, Reg_Dst=10, Mem_to_Reg=10 -> FETCH; retires.
- Latency with mem_ready tied high:
  - R/I-type, sw: 4 cycles.
  - lw: 5 cycles.
  - branch/jump: 3 cycles.
- instr_count increments by 1 in the retiring cycle and wraps from 2^CNT_W-1 to 0.
- Mem_Read and Mem_Write are never high together.
- Opcode changes outside DECODE are ignored.
- Reset asserted mid-instruction aborts it immediately: no further writes, instr_count=0.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - opcode localparams (R, LW, SW, ADDI, ANDI, ORI, SLTI, XORI, BEQ, BNE, J, JAL, LUI)
  - ALU_Op encodings
  - Reg_Dst / Mem_to_Reg / ALU_Src_B / PC_Source selector encodings
  - state enum
- One sub-module: mc_opcode_decode, combinational. Maps op_q to class, I-type ALU_Op and a legal flag; it is reused by the FSM next-state and output logic.

Test Plan:
- Reset low, then release; mem_ready=1, Opcode=0 -> states IDLE, FETCH, DECODE, EXEC_R, ALU_WB; ALU_WB has Reg_Write=1, Reg_Dst=01; instr_count=1 after 4 cycles from FETCH.
- Opcode=35, mem_ready low for 3 cycles in MEM_READ -> Mem_Read and IorD held at 1 for 4 cycles; MEM_WB has Reg_Write=1, Mem_to_Reg=01; total 8 cycles.
- Opcode=5 -> BRANCH drives PC_Write_Not_Equal=1, PC_Write_Cond=0, ALU_Op=001; Opcode=4 -> PC_Write_Cond=1.
- Opcode=3 (jal) -> JUMP drives PC_Write=1, PC_Source=10, Reg_Write=1, Reg_Dst=10, Mem_to_Reg=10; back to FETCH after 3 cycles.
- Opcode=63 -> illegal_op pulses 1 cycle in DECODE, returns to FETCH, instr_count unchanged.
- Reset asserted during MEM_WRITE -> Mem_Write=0 asynchronously, instr_count=0; CNT_W=4 with 16 retired instructions -> instr_count wraps to 0.
